font_row_serializer: RTL

Downstream stage of the 8x16 glyph-address generator and the 8x16 font ROM in the on-screen text overlay (HORA / DIA MES ANO / CRONOMETRO labels). It takes the 8-bit font row returned by the ROM for each character cell and shifts it out one pixel per pixel tick. It keeps the pixel column, pixel tick and video-active flag aligned with the address-plus-ROM latency. It drives a registered 12-bit RGB value and a 1-bit overlay flag to the VGA colour mux.

---
 rtl/font_row_serializer.sv | 80 ++++++++
 1 files changed

// File: rtl/font_row_serializer.sv
// Serializes one 8-pixel font row per character cell into registered RGB and overlay flag,
// keeping tick, video-active and column aligned with the glyph-address plus ROM read latency.
module font_row_serializer #(
    parameter int LAT = 2
) (
    input  logic        reloj,
    input  logic        resetM,
    input  logic        pix_tick,
    input  logic        video_on,
    input  logic [2:0]  col_px,
    input  logic [7:0]  rom_data,
    input  logic [11:0] fg_rgb,
    input  logic [11:0] bg_rgb,
    output logic [11:0] rgb,
    output logic        pix_on
);

    logic [LAT-1:0] tick_d;
    logic [LAT-1:0] vo_d;
    logic [2:0]     col_d [LAT];
    logic [7:0]     shreg;
    logic           tick_l;
    logic           vo_l;
    logic [2:0]     col_l;
    logic           pix_bit;

    assign tick_l = tick_d[LAT-1];
    assign vo_l   = vo_d[LAT-1];
    assign col_l  = col_d[LAT-1];

    // Alignment chains run every clock so the tail stage lines up with rom_data.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            tick_d <= '0;
            vo_d   <= '0;
            for (int i = 0; i < LAT; i++) begin
                col_d[i] <= 3'd0;
            end
        end else begin
            // NOTE: registers use non-blocking assignments so every stage samples
            // the previous stage's pre-edge value, giving a true shift chain.
            tick_d[0] <= pix_tick;
            vo_d[0]   <= video_on;
            col_d[0]  <= col_px;
            for (int i = 1; i < LAT; i++) begin
                tick_d[i] <= tick_d[i-1];
                vo_d[i]   <= vo_d[i-1];
                col_d[i]  <= col_d[i-1];
            end
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns pix_bit and no latch is inferred.
        pix_bit = 1'b0;
        if (vo_l) begin
            pix_bit = (col_l == 3'd0) ? rom_data[7] : shreg[6];
        end
    end

    // Load on column 0, shift otherwise; blanking clears so a mid-cell entry shows background.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            shreg  <= 8'h00;
            rgb    <= 12'h000;
            pix_on <= 1'b0;
        end else if (tick_l) begin
            if (!vo_l) begin
                shreg  <= 8'h00;
                rgb    <= 12'h000;
                pix_on <= 1'b0;
            end else begin
                shreg  <= (col_l == 3'd0) ? rom_data : {shreg[6:0], 1'b0};
                pix_on <= pix_bit;
                rgb    <= pix_bit ? fg_rgb : bg_rgb;
            end
        end
    end

endmodule
